// File: rtl/decoder_pkg.sv
// Shared RV32I decode definitions: instruction classes, ALU operations and
// opcode constants, also consumed by the execute stage.
package decoder_pkg;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_ALU_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_EQ,
    ALU_NE,
    ALU_LT,
    ALU_GE,
    ALU_LTU,
    ALU_GEU
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Integer op from funct3; alt selects SUB/SRA over ADD/SRL.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic class_writes_rd(input instr_class_e cls);
    case (cls)
      CLS_ALU, CLS_ALU_IMM, CLS_LOAD, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decoder_imm_gen.sv
// Combinational immediate extraction; the class selects the RV32I format.
// Opcode bits are not needed, so only instr[31:7] is taken.
module imm_gen
  import decoder_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [3:0]  instr_class,
  output logic [31:0] imm
);

  instr_class_e cls;
  assign cls = instr_class_e'(instr_class);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm = '0;
    case (cls)
      CLS_ALU_IMM, CLS_LOAD, CLS_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      CLS_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm = {instr[31:12], 12'b0};
      CLS_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Single-cycle RV32I instruction decoder: captures pc/instr_raw on an enabled
// pulse and holds the decoded fields until the next pulse.
module decoder
  import decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic [31:0] pc,
  input  logic [31:0] instr_raw,
  output logic        completed,
  output logic [31:0] pc_out,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [3:0]  instr_class,
  output logic [3:0]  alu_op,
  output logic [2:0]  funct3,
  output logic        reg_we
);

  typedef enum logic {S_IDLE, S_DONE} state_e;

  state_e       state;
  instr_class_e dec_cls;
  alu_op_e      dec_op;
  logic [31:0]  dec_imm;
  logic         dec_we;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;

  assign opcode = instr_raw[6:0];
  assign funct7 = instr_raw[31:25];
  assign f3     = instr_raw[14:12];

  always_comb begin
    dec_cls = CLS_ILLEGAL;
    dec_op  = ALU_ADD;
    if (instr_raw[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP: begin
          if (funct7 == FUNCT7_BASE ||
              (funct7 == FUNCT7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
            dec_cls = CLS_ALU;
            dec_op  = alu_from_funct3(f3, funct7[5]);
          end
        end
        OPC_OP_IMM: begin
          // Only the shift-immediates constrain funct7; addi never becomes SUB.
          if (!(f3 == 3'b001 && funct7 != FUNCT7_BASE) &&
              !(f3 == 3'b101 && funct7 != FUNCT7_BASE && funct7 != FUNCT7_ALT)) begin
            dec_cls = CLS_ALU_IMM;
            dec_op  = alu_from_funct3(f3, (f3 == 3'b101) && instr_raw[30]);
          end
        end
        OPC_BRANCH: begin
          dec_cls = CLS_BRANCH;
          case (f3)
            3'b000:  dec_op = ALU_EQ;
            3'b001:  dec_op = ALU_NE;
            3'b100:  dec_op = ALU_LT;
            3'b101:  dec_op = ALU_GE;
            3'b110:  dec_op = ALU_LTU;
            3'b111:  dec_op = ALU_GEU;
            default: begin
              dec_cls = CLS_ILLEGAL;
              dec_op  = ALU_ADD;
            end
          endcase
        end
        OPC_LOAD:   dec_cls = CLS_LOAD;
        OPC_STORE:  dec_cls = CLS_STORE;
        OPC_JAL:    dec_cls = CLS_JAL;
        OPC_JALR:   dec_cls = CLS_JALR;
        OPC_LUI:    dec_cls = CLS_LUI;
        OPC_AUIPC:  dec_cls = CLS_AUIPC;
        OPC_SYSTEM: dec_cls = CLS_SYSTEM;
        default:    dec_cls = CLS_ILLEGAL;
      endcase
    end
  end

  assign dec_we = class_writes_rd(dec_cls) && (instr_raw[11:7] != 5'd0);

  imm_gen u_imm_gen (
    .instr       (instr_raw[31:7]),
    .instr_class (dec_cls),
    .imm         (dec_imm)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_out      <= '0;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      imm         <= '0;
      instr_class <= CLS_ILLEGAL;
      alu_op      <= ALU_ADD;
      funct3      <= '0;
      reg_we      <= 1'b0;
    end else if (enabled) begin
      state       <= S_DONE;
      pc_out      <= pc;
      rd          <= instr_raw[11:7];
      rs1         <= instr_raw[19:15];
      rs2         <= instr_raw[24:20];
      imm         <= dec_imm;
      instr_class <= dec_cls;
      alu_op      <= dec_op;
      funct3      <= f3;
      reg_we      <= dec_we;
    end
  end

  // Masked while a new capture is in flight so consumers never see a stale result.
  assign completed = (state == S_DONE) && !enabled;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: expected results are queued when an
// instruction is pulsed in and popped when completed rises.
module tb_decoder;
  import decoder_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        we;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic        completed;
  logic [31:0] pc_out;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [3:0]  instr_class;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic        reg_we;

  res_t dut_res;
  res_t exp_r;
  res_t reset_val;
  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder dut (
    .clk         (clk),
    .rst         (rst),
    .enabled     (enabled),
    .pc          (pc),
    .instr_raw   (instr_raw),
    .completed   (completed),
    .pc_out      (pc_out),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .instr_class (instr_class),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .reg_we      (reg_we)
  );

  assign dut_res = {pc_out, instr_class, alu_op, rd, rs1, rs2, imm, funct3, reg_we};

  function automatic res_t mk(input logic [31:0] p, input instr_class_e c, input alu_op_e o,
                              input int d, input int s1, input int s2,
                              input logic [31:0] i, input int f, input logic w);
    res_t r;
    r.pc = p; r.cls = c; r.op = o;
    r.rd = 5'(d); r.rs1 = 5'(s1); r.rs2 = 5'(s2);
    r.imm = i; r.f3 = 3'(f); r.we = w;
    return r;
  endfunction

  // Drive a one-cycle enabled pulse and queue what the decoder should produce.
  task automatic pulse(input logic [31:0] p, input logic [31:0] i, input res_t e);
    @(posedge clk); #1;
    enabled = 1'b1; pc = p; instr_raw = i;
    sb.push_back(e);
    @(posedge clk); #1;
    enabled = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (completed !== 1'b0 || dut_res !== reset_val) begin
      errors++;
      $display("FAIL reset_async: completed=%b got %h want %h", completed, dut_res, reset_val);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (completed !== 1'b0 || dut_res !== reset_val) begin
      errors++;
      $display("FAIL reset_release: completed=%b got %h want %h", completed, dut_res, reset_val);
    end
  endtask

  task automatic test_addi();
    pulse(32'h100, 32'h00500093, mk(32'h100, CLS_ALU_IMM, ALU_ADD, 1, 0, 5, 32'd5, 0, 1'b1));
    @(negedge clk);
    exp_r = sb.pop_front();
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL addi: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL addi_hold: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
  endtask

  task automatic test_store();
    pulse(32'h104, 32'h0020A423, mk(32'h104, CLS_STORE, ALU_ADD, 8, 1, 2, 32'd8, 2, 1'b0));
    @(negedge clk);
    exp_r = sb.pop_front();
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL sw: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    pulse(32'h108, 32'hFE000EE3, mk(32'h108, CLS_BRANCH, ALU_EQ, 29, 0, 0, 32'hFFFFFFFC, 0, 1'b0));
    @(negedge clk);
    exp_r = sb.pop_front();
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL beq: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
    // Overwrite the held result while in DONE.
    @(posedge clk); #1;
    enabled = 1'b1; pc = 32'h10C; instr_raw = 32'h123452B7;
    sb.push_back(mk(32'h10C, CLS_LUI, ALU_ADD, 5, 8, 3, 32'h12345000, 5, 1'b1));
    @(negedge clk);
    checks++;
    if (completed !== 1'b0) begin
      errors++;
      $display("FAIL lui_mask: completed=%b want 0", completed);
    end
    @(posedge clk); #1 enabled = 1'b0;
    @(negedge clk);
    exp_r = sb.pop_front();
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL lui: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
  endtask

  task automatic test_decode_table();
    vec_t tbl[$];
    tbl.push_back('{32'h0000006F, 32'h200, mk(32'h200, CLS_JAL,     ALU_ADD, 0, 0, 0, 32'h0, 0, 1'b0)});
    tbl.push_back('{32'h00000000, 32'h204, mk(32'h204, CLS_ILLEGAL, ALU_ADD, 0, 0, 0, 32'h0, 0, 1'b0)});
    tbl.push_back('{32'h402081B3, 32'h208, mk(32'h208, CLS_ALU,     ALU_SUB, 3, 1, 2, 32'h0, 0, 1'b1)});
    tbl.push_back('{32'h202081B3, 32'h20C, mk(32'h20C, CLS_ILLEGAL, ALU_ADD, 3, 1, 2, 32'h0, 0, 1'b0)});
    tbl.push_back('{32'h40325213, 32'h210, mk(32'h210, CLS_ALU_IMM, ALU_SRA, 4, 4, 3, 32'h403, 5, 1'b1)});
    tbl.push_back('{32'hFE002EE3, 32'h214, mk(32'h214, CLS_ILLEGAL, ALU_ADD, 29, 0, 0, 32'h0, 2, 1'b0)});
    tbl.push_back('{32'h00500091, 32'h218, mk(32'h218, CLS_ILLEGAL, ALU_ADD, 1, 0, 5, 32'h0, 0, 1'b0)});
    tbl.push_back('{32'hFFC12303, 32'h21C, mk(32'h21C, CLS_LOAD,    ALU_ADD, 6, 2, 28, 32'hFFFFFFFC, 2, 1'b1)});
    tbl.push_back('{32'h000280E7, 32'h220, mk(32'h220, CLS_JALR,    ALU_ADD, 1, 5, 0, 32'h0, 0, 1'b1)});
    tbl.push_back('{32'h0020C463, 32'h224, mk(32'h224, CLS_BRANCH,  ALU_LT,  8, 1, 2, 32'h8, 4, 1'b0)});
    tbl.push_back('{32'h00000073, 32'h228, mk(32'h228, CLS_SYSTEM,  ALU_ADD, 0, 0, 0, 32'h0, 0, 1'b0)});
    foreach (tbl[k]) begin
      pulse(tbl[k].pc, tbl[k].instr, tbl[k].exp);
      @(negedge clk);
      exp_r = sb.pop_front();
      checks++;
      if (completed !== 1'b1 || dut_res !== exp_r) begin
        errors++;
        $display("FAIL table[%0d] instr=%h: completed=%b got %h want %h",
                 k, tbl[k].instr, completed, dut_res, exp_r);
      end
    end
  endtask

  task automatic test_held_enable();
    logic [31:0] instrs [3] = '{32'h00500093, 32'h0020A423, 32'h123452B7};
    res_t        exps   [3];
    exps[0] = mk(32'h300, CLS_ALU_IMM, ALU_ADD, 1, 0, 5, 32'd5, 0, 1'b1);
    exps[1] = mk(32'h304, CLS_STORE,   ALU_ADD, 8, 1, 2, 32'd8, 2, 1'b0);
    exps[2] = mk(32'h308, CLS_LUI,     ALU_ADD, 5, 8, 3, 32'h12345000, 5, 1'b1);
    @(posedge clk); #1;
    enabled = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h300 + 32'(4 * k);
      instr_raw = instrs[k];
      sb.push_back(exps[k]);
      @(negedge clk);
      checks++;
      if (completed !== 1'b0) begin
        errors++;
        $display("FAIL held_mask[%0d]: completed=%b want 0", k, completed);
      end
      @(posedge clk); #1;
    end
    enabled = 1'b0;
    @(negedge clk);
    // Earlier captures were overwritten; only the last one is observable.
    while (sb.size() > 1) void'(sb.pop_front());
    exp_r = sb.pop_front();
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL held_last: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
  endtask

  task automatic test_mid_reset();
    pulse(32'h400, 32'h00500093, mk(32'h400, CLS_ALU_IMM, ALU_ADD, 1, 0, 5, 32'd5, 0, 1'b1));
    @(negedge clk);
    exp_r = sb.pop_front();
    checks++;
    if (completed !== 1'b1 || dut_res !== exp_r) begin
      errors++;
      $display("FAIL pre_reset: completed=%b got %h want %h", completed, dut_res, exp_r);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (completed !== 1'b0 || dut_res !== reset_val) begin
      errors++;
      $display("FAIL mid_reset: completed=%b got %h want %h", completed, dut_res, reset_val);
    end
    // enabled coincident with reset must be ignored.
    @(posedge clk); #1;
    enabled = 1'b1; pc = 32'h404; instr_raw = 32'h123452B7;
    @(posedge clk); #1;
    enabled = 1'b0;
    @(negedge clk);
    checks++;
    if (completed !== 1'b0 || dut_res !== reset_val) begin
      errors++;
      $display("FAIL reset_enable: completed=%b got %h want %h", completed, dut_res, reset_val);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (completed !== 1'b0 || dut_res !== reset_val) begin
      errors++;
      $display("FAIL post_reset_idle: completed=%b got %h want %h", completed, dut_res, reset_val);
    end
  endtask

  initial begin
    rst = 1'b1; enabled = 1'b0; pc = '0; instr_raw = '0;
    reset_val = mk(32'h0, CLS_ILLEGAL, ALU_ADD, 0, 0, 0, 32'h0, 0, 1'b0);
    test_reset();
    test_addi();
    test_store();
    test_back_to_back();
    test_decode_table();
    test_held_enable();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed at 32-bit instruction and 32-bit PC.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 enabled  input  1  one-cycle start pulse from the controller; marks instr_raw/pc as valid this cycle.
REQ-005 pc  input  32  PC of the fetched instruction (fetch pc_n).
REQ-006 instr_raw  input  32  raw instruction word from fetch.
REQ-007 completed  output  1  decoded outputs valid; combinationally masked low while enabled is high.
REQ-008 pc_out  output  32  registered copy of pc.
REQ-009 rd, rs1, rs2  output  5 each  register indices from bits [11:7], [19:15], [24:20].
REQ-010 imm  output  32  sign-extended immediate for the instruction format.
REQ-011 instr_class  output  4  class enum: ALU, ALU_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL.
REQ-012 alu_op  output  4  enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, EQ, NE, LT, GE, LTU, GEU.
REQ-013 funct3  output  3  bits [14:12], passed through for load/store width.
REQ-014 reg_we  output  1  instruction writes rd; SHALL be 0 when rd==0.

Function
REQ-015 The block SHALL run a two-state FSM: IDLE (no valid result) and DONE (result held).
REQ-016 On a cycle with enabled=1, the block SHALL capture pc and instr_raw and register all decoded outputs at that edge; FSM SHALL enter DONE.
REQ-017 Latency SHALL be one cycle: outputs valid and completed=1 in the cycle after the enabled pulse.
REQ-018 completed SHALL equal (state==DONE) AND NOT enabled; outputs SHALL hold stable until the next enabled pulse.
REQ-019 enabled asserted while in DONE SHALL overwrite the held result; completed SHALL drop for that cycle and rise the next.
REQ-020 enabled held high for several cycles SHALL recapture every cycle; completed SHALL stay 0 until enabled falls.
REQ-021 Immediates: I = sext[31:20]; S = sext{[31:25],[11:7]}; B = sext{[31],[7],[30:25],[11:8],0}; U = {[31:12],12'b0}; J = sext{[31],[19:12],[20],[30:21],0}; ALU/SYSTEM imm SHALL be 0.
REQ-022 alu_op SHALL be ADD for LOAD, STORE, JAL, JALR, LUI, AUIPC; SUB only for OP with funct7=0100000, funct3=000; SRA for shift-right with bit30=1; BRANCH SHALL map funct3 to EQ/NE/LT/GE/LTU/GEU.
REQ-023 Unknown opcode, BRANCH funct3 010/011, illegal funct7 on OP or shift-immediate, or bits[1:0]!=11 SHALL give ILLEGAL, reg_we=0, imm=0, alu_op=ADD.
REQ-024 reg_we SHALL be 1 for ALU, ALU_IMM, LOAD, JAL, JALR, LUI, AUIPC when rd!=0; 0 otherwise.

Reset
REQ-025 rst=1 SHALL immediately force FSM to IDLE and completed=0, regardless of clock.
REQ-026 Reset values: pc_out=0, rd=rs1=rs2=0, imm=0, funct3=0, instr_class=ILLEGAL, alu_op=ADD, reg_we=0.
REQ-027 Reset during DONE SHALL discard the held result; an enabled pulse coincident with rst SHALL be ignored.

Structure
REQ-028 instr_class and alu_op enums and the RV32I opcode constants SHALL live in the shared definitions package, for use by the execute stage.
REQ-029 Immediate extraction SHALL be a combinational sub-module imm_gen (inputs instr, class; output imm).

Verification
REQ-030 addi x1,x0,5 (0x00500093), pc=0x100 -> next cycle completed=1, ALU_IMM, ADD, rd=1, rs1=0, imm=5, reg_we=1, pc_out=0x100.
REQ-031 sw x2,8(x1) (0x0020A423) -> STORE, rs1=1, rs2=2, imm=8, funct3=010, reg_we=0.
REQ-032 beq x0,x0,-4 (0xFE000EE3) -> BRANCH, EQ, imm=0xFFFFFFFC; then lui x5,0x12345 (0x123452B7) pulsed while in DONE -> completed low 1 cycle, then LUI, imm=0x12345000, rd=5.
REQ-033 jal x0,0 (0x0000006F) -> JAL, imm=0, reg_we=0 (rd=0); 0x00000000 -> ILLEGAL, reg_we=0.
REQ-034 rst asserted mid-cycle while completed=1 -> completed=0 and all outputs at reset values before the next clock edge.
